// File: rtl/uart_pkg.sv
// Shared definitions for the GPS UART receiver and the NMEA parser stage.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } rx_state_e;

    localparam int OVERSAMPLE = 16;

    // Oversample positions around mid-bit used for the majority vote.
    localparam logic [3:0] SAMPLE_A  = 4'd7;
    localparam logic [3:0] SAMPLE_B  = 4'd8;
    localparam logic [3:0] SAMPLE_C  = 4'd9;
    localparam logic [3:0] LAST_TICK = 4'd15;

    localparam logic [7:0] ASCII_DOLLAR = 8'h24;
    localparam logic [7:0] ASCII_STAR   = 8'h2A;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_nmea_if.sv
// Received-byte stream from the UART receiver to the NMEA parser.
interface uart_rx_nmea_if;
    logic [7:0] po_data;
    logic       po_flag;
    logic       frame_err;

    modport master (output po_data, output po_flag, output frame_err);
    modport slave  (input  po_data, input  po_flag, input  frame_err);
endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle pulse every DIV clocks, phase reset by clr.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    if (DIV < 4) begin : g_div_check
        $error("uart_baud_tick: clock too slow for requested baud rate");
    end

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Divider next-count: wrap at DIV-1, restart on clr.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Divider counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST) && !clr;

endmodule

// File: rtl/uart_rx_nmea.sv
// 8N1 UART receiver with 16x oversampling and 3-sample majority vote,
// feeding received bytes to the NMEA parser.
module uart_rx_nmea
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600
) (
    input  logic           sys_clk,
    input  logic           sys_rst_n,
    input  logic           rx,
    uart_rx_nmea_if.master byte_out
);

    rx_state_e  state_q, state_d;
    logic       rx_meta_q, rx_s_q, rx_d_q;
    logic [3:0] tick_cnt_q, tick_cnt_d;
    logic [3:0] bit_idx_q, bit_idx_d;
    logic [7:0] shift_q, shift_d;
    logic       samp_a_q, samp_a_d;
    logic       samp_b_q, samp_b_d;
    logic [7:0] po_data_q, po_data_d;
    logic       po_flag_q, po_flag_d;
    logic       frame_err_q, frame_err_d;
    logic       baud_clr_s;
    logic       tick_s;
    logic       mid_tick_s;
    logic       end_tick_s;
    logic       maj_s;

    uart_baud_tick #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) u_baud_tick (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .clr   (baud_clr_s),
        .tick  (tick_s)
    );

    assign mid_tick_s = tick_s && (tick_cnt_q == SAMPLE_C);
    assign end_tick_s = tick_s && (tick_cnt_q == LAST_TICK);
    assign maj_s      = maj3(samp_a_q, samp_b_q, rx_s_q);

    // Receive FSM next-state, datapath and strobe generation.
    always_comb begin
        state_d     = state_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        po_data_d   = po_data_q;
        po_flag_d   = 1'b0;
        frame_err_d = 1'b0;
        baud_clr_s  = 1'b0;

        case (state_q)
            IDLE: begin
                if (rx_d_q && !rx_s_q) begin
                    state_d    = START;
                    baud_clr_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (mid_tick_s) begin
                    if (maj_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = DATA;
                        bit_idx_d = 4'd0;
                    end
                end else begin
                    state_d = START;
                end
            end
            DATA: begin
                // bit_idx counts bits already shifted in, so the tail of the
                // start bit (entered mid-bit) never advances the frame.
                if (mid_tick_s) begin
                    shift_d   = {maj_s, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 4'd1;
                end else if (end_tick_s && (bit_idx_q == 4'd8)) begin
                    state_d = STOP;
                end else begin
                    state_d = DATA;
                end
            end
            STOP: begin
                if (mid_tick_s) begin
                    if (maj_s) begin
                        po_data_d = shift_q;
                        po_flag_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = WAIT_HIGH;
                    end
                end else begin
                    state_d = STOP;
                end
            end
            WAIT_HIGH: begin
                if (rx_s_q) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_HIGH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (baud_clr_s) begin
            tick_cnt_d = 4'd0;
        end else if (tick_s) begin
            tick_cnt_d = tick_cnt_q + 4'd1;
        end else begin
            tick_cnt_d = tick_cnt_q;
        end

        if (tick_s && (tick_cnt_q == SAMPLE_A)) begin
            samp_a_d = rx_s_q;
        end else begin
            samp_a_d = samp_a_q;
        end

        if (tick_s && (tick_cnt_q == SAMPLE_B)) begin
            samp_b_d = rx_s_q;
        end else begin
            samp_b_d = samp_b_q;
        end
    end

    // Line synchronizer plus edge-detect stage; reset to idle-high.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_d_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            rx_d_q    <= rx_s_q;
        end
    end

    // FSM, counters, shift register and output registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= IDLE;
            tick_cnt_q  <= 4'd0;
            bit_idx_q   <= 4'd0;
            shift_q     <= 8'h00;
            samp_a_q    <= 1'b1;
            samp_b_q    <= 1'b1;
            po_data_q   <= 8'h00;
            po_flag_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            samp_a_q    <= samp_a_d;
            samp_b_q    <= samp_b_d;
            po_data_q   <= po_data_d;
            po_flag_q   <= po_flag_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign byte_out.po_data   = po_data_q;
    assign byte_out.po_flag   = po_flag_q;
    assign byte_out.frame_err = frame_err_q;

endmodule
